// File: rtl/eq_pkg.sv
// eq_pkg: shared constants and types for the equalizer gain path.
//   NUM_BANDS   - number of gain bands (one writable register each)
//   GAIN_W      - gain register width, also the SPI byte width
//   REG_ADDR_W  - register-map address width
//   spi_state_e - SPI frame FSM states
package eq_pkg;

  localparam int unsigned NUM_BANDS  = 10;
  localparam int unsigned GAIN_W     = 8;
  localparam int unsigned REG_ADDR_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StWaitEnd
  } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async active-low reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (ResetVal while in reset)
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_q, ff2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= ResetVal;
      ff2_q <= ResetVal;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/spi_gain_loader.sv
// spi_gain_loader: SPI mode-0 slave that turns (address, data) frames into single-cycle
// register-map write strobes, all in the clk domain.
//   clk, rst_n          - system clock, async active-low reset
//   sclk, cs_n, mosi    - raw SPI pins (asynchronous to clk)
//   we, addr, data_out  - write strobe; addr/data_out hold between writes
//   addr_err            - one-cycle pulse for a data byte aimed at addr >= NUM_REGS
//   busy                - FSM not idle
// Build option: define SPI_AUTOINC_EN for burst writes with an auto-incrementing address.
module spi_gain_loader
  import eq_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_BANDS,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DATA_W   = GAIN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              addr_err,
  output logic              busy
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_s, cs_n_s, mosi_s;

  sync_2ff #(.ResetVal(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_2ff #(.ResetVal(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));
  sync_2ff #(.ResetVal(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  // Edge detection. Edges are ignored until the synchronizers and the history flops hold
  // real pin samples, so a cs_n already low at reset release never looks like a fall.
  logic       sclk_prev_q, cs_n_prev_q;
  logic [1:0] arm_q;
  logic       armed;
  logic       sclk_rise_q, cs_fall_q, cs_rise_q, bit_q;

  assign armed = (arm_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      arm_q       <= 2'd0;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
      if (!armed) arm_q <= arm_q + 2'd1;
      sclk_rise_q <= armed & sclk_s & ~sclk_prev_q;
      cs_fall_q   <= armed & cs_n_prev_q & ~cs_n_s;
      cs_rise_q   <= armed & ~cs_n_prev_q & cs_n_s;
      bit_q       <= mosi_s;
    end
  end

  // Frame FSM and registered outputs.
  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_int_q, addr_int_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d, err_q, err_d;
  logic [DATA_W-1:0] byte_val;
  logic              byte_done, in_range;

  assign byte_val  = {shift_q, bit_q};
  assign byte_done = sclk_rise_q && (cnt_q == LastBit);
  assign in_range  = (32'(addr_int_q) < NUM_REGS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_int_d = addr_int_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    err_d      = 1'b0;

    if ((state_q == StAddr || state_q == StData) && sclk_rise_q) begin
      shift_d = byte_val[DATA_W-2:0];
      cnt_d   = byte_done ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall_q) begin
          state_d = StAddr;
          cnt_d   = '0;
        end
      end
      StAddr: begin
        if (byte_done) begin
          addr_int_d = ADDR_W'(byte_val);
          state_d    = StData;
        end
      end
      StData: begin
        if (byte_done) begin
          if (in_range) begin
            we_d   = 1'b1;
            addr_d = addr_int_q;
            data_d = byte_val;
          end else begin
            err_d = 1'b1;
          end
`ifdef SPI_AUTOINC_EN
          addr_int_d = addr_int_q + ADDR_W'(1);
`else
          state_d = StWaitEnd;
`endif
        end
      end
      StWaitEnd: ;
      default: state_d = StIdle;
    endcase

    // cs_n rise wins over everything except a byte completing in the same cycle.
    if (cs_rise_q) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      addr_int_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_int_q <= addr_int_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign we       = we_q;
  assign addr     = addr_q;
  assign data_out = data_q;
  assign addr_err = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: doc/spi_gain_loader.md
# spi_gain_loader

SPI-slave-to-register-write bridge that sits directly upstream of the equalizer gain register map. Deserializes host SPI frames (address byte, then data byte) in the system clock domain and emits single-cycle `we`/`addr`/`data_out` write strobes that drive the register map's `we`/`addr`/`data_in` inputs. Out-of-range addresses are rejected with an error pulse instead of a write.

## Interface
- `NUM_REGS`, 10: number of valid gain registers; writable addresses are 0..NUM_REGS-1.
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width; also the bits per SPI byte.

- `clk`  in  1  system clock (50 MHz); all logic is in this domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`; mode 0.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, MSB first.
- `we`  out  1  one-`clk` write strobe.
- `addr`  out  ADDR_W  write address; valid while `we`=1, held afterwards.
- `data_out`  out  DATA_W  write data; valid while `we`=1, held afterwards.
- `addr_err`  out  1  one-`clk` pulse when a data byte completes for an address ≥ NUM_REGS.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchronizer. The `sclk` rising edge is detected on the synchronized signal. The `cs_n` falling and rising edges are detected the same way.
- Constraint: the `clk` frequency is ≥ 8× the `sclk` frequency. Behaviour is undefined otherwise.
- Shift register: on each detected `sclk` rise, shift in the synchronized `mosi` (MSB first) and increment a 3-bit bit counter.
- FSM states:
  - IDLE → ADDR on a `cs_n` fall. The bit counter clears.
  - ADDR: at the 8th bit, latch the address internally, then go to DATA.
  - DATA: at the 8th bit, if the address is < NUM_REGS, drive `addr` and `data_out` and pulse `we`. Otherwise pulse `addr_err`, issue no `we`, and leave `addr`/`data_out` unchanged. Then go to WAIT_END.
  - WAIT_END: ignore all `sclk` edges until `cs_n` rises.
- A `cs_n` rise in any state → IDLE. The bit counter clears and a partial byte is discarded with no `we` and no `addr_err`.
- Simultaneous events: if the 8th-bit edge and the `cs_n` rise are detected in the same `clk` cycle, the byte is completed (write or error issued) and the next state is IDLE.
- Frame start requires a detected `cs_n` falling edge. If `cs_n` is already low when reset releases, the block stays in IDLE until `cs_n` rises and falls again.
- Reset mid-frame: the FSM returns to IDLE, all outputs return to their reset values, and the partial frame is lost.
- `addr` and `data_out` change only on a `we` cycle.

## Timing
- Reset values: `we`=0, `addr`=0, `data_out`=0, `addr_err`=0, `busy`=0, state IDLE.
- Write latency: `we` or `addr_err` asserts exactly 3 `clk` cycles after the first `clk` edge that samples the raw 16th `sclk` rise as high (2 cycles synchronizer, 1 cycle edge detect and commit).
- `we` and `addr_err` are high for exactly 1 `clk` cycle. They are never asserted together.
- `busy` rises 3 `clk` cycles after the raw `cs_n` fall is first sampled. It falls 3 cycles after the raw `cs_n` rise is first sampled.
- Outputs are registered, with no combinational path from the SPI pins.

## Configuration
- `SPI_AUTOINC_EN` defined: after each completed data byte, DATA stays in DATA and the internal address increments by 1, so a burst `addr, d0, d1, …` writes consecutive registers.
  - Each byte is checked independently: a byte whose address is ≥ NUM_REGS pulses `addr_err`.
  - The address wraps modulo 2^ADDR_W.
  - WAIT_END is unused.
- `SPI_AUTOINC_EN` undefined: one write per frame, as described in Operation; extra bytes are ignored.

## Structure
- Shared package `eq_pkg`: `NUM_BANDS`=10 (the source of NUM_REGS), `GAIN_W`=8, `REG_ADDR_W`=8, and the FSM state enum (IDLE, ADDR, DATA, WAIT_END).
- Sub-module `sync_2ff`: 1-bit two-flop synchronizer with async active-low reset, instantiated three times.
  - Reset value is 0 for the `sclk` and `mosi` instances.
  - Reset value is 1 for the `cs_n` instance, so there is no false frame start after reset.

## Test plan
- Frame `0x03, 0xA5` at `sclk` = 5 MHz → one `we` pulse with `addr`=0x03 and `data_out`=0xA5 exactly 3 `clk` cycles after the 16th `sclk` rise; `addr_err` stays 0.
- Frame `0x0C, 0x55` → `addr_err` pulses once, `we` stays 0, and `addr`/`data_out` keep their previous values.
- `cs_n` raised after 12 bits of `0x02, 0x7F` → no `we`, no `addr_err`, `busy` falls. A following full frame `0x02, 0x7F` writes normally.
- Frame `0x01, 0x11, 0x22` without the macro → single write to addr 1 with 0x11. With `SPI_AUTOINC_EN` → writes addr 1 = 0x11, then addr 2 = 0x22.
- With `SPI_AUTOINC_EN`, frame `0x09, 0x01, 0x02` → `we` at addr 9, then `addr_err`.
- `rst_n` asserted after 4 data bits → all outputs 0 immediately. With `cs_n` held low through reset release, subsequent `sclk` activity produces no write until a new `cs_n` fall.
- Loopback into the register map: ten frames writing i*2 to addresses 0..9 → `gain_1`..`gain_10` read 00, 02, …, 12 (hex).
